// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction prefetch slice.
package ifu_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam logic [31:0] DEF_RESET_PC   = 32'h8000_0000;

  // FIFO word layout {fault, pc, inst} for the default address width.
  localparam int unsigned FIFO_WORD_W = DEF_ADDR_WIDTH + 33;
  localparam int unsigned FAULT_BIT   = FIFO_WORD_W - 1;
  localparam int unsigned PC_LSB      = 32;
  localparam int unsigned INST_LSB    = 0;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } state_t;

endpackage

// File: rtl/ifu_credit.sv
// FIFO occupancy tracker: counts pushes minus effective pops so a
// producer can avoid overflowing a FIFO that has no full flag.
module ifu_credit import ifu_pkg::*; #(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  logic pop,
  input  logic flush,
  output logic has_space,
  output logic has_space_next
);

  localparam int unsigned CW = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2:0] occ;
  logic [DEPTH_LOG2:0] occ_next;
  logic                pop_eff;

  // Next occupancy; a pop on an empty FIFO or during a flush is ignored.
  always_comb begin
    pop_eff  = pop && (occ != '0);
    occ_next = occ;
    if (flush) begin
      occ_next = '0;
    end else begin
      occ_next = occ + CW'(push) - CW'(pop_eff);
    end
  end

  // Space indications for the current and the following cycle.
  always_comb begin
    has_space      = (occ < DEPTH);
    has_space_next = (occ_next < DEPTH);
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ <= '0;
    end else begin
      occ <= occ_next;
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch stage: issues sequential word reads, pushes
// {fault, pc, inst} into the instruction FIFO, and restarts on redirect.
module ifu_prefetch import ifu_pkg::*; #(
  parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned           DEPTH_LOG2 = 6,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEF_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  output logic                  fifo_wready,
  output logic [ADDR_WIDTH+32:0] fifo_wdata,
  output logic                  fifo_flush,
  input  logic                  fifo_pop
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  kill;
  logic                  has_space;
  logic                  has_space_next;
  logic [ADDR_WIDTH-1:0] pc_seq;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  resp_fault;

  // Push, flush and datapath toward the FIFO.
  always_comb begin
    resp_fault      = |rresp;
    fifo_flush      = redirect_valid;
    fifo_wready     = (state == WAIT) && rvalid && !kill && !redirect_valid;
    fifo_wdata      = {resp_fault, req_addr, rdata};
    araddr          = req_addr;
    pc_seq          = pc + ADDR_WIDTH'(4);
    redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  end

  ifu_credit #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_credit (
    .clk            (clk),
    .rstn           (rstn),
    .push           (fifo_wready),
    .pop            (fifo_pop),
    .flush          (redirect_valid),
    .has_space      (has_space),
    .has_space_next (has_space_next)
  );

  // Fetch sequencer with registered bus handshake outputs.
  // A redirect never abandons an issued request: the address phase is held
  // until accepted and the response is then discarded via kill.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      kill     <= 1'b0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc <= redirect_target;
      end
      case (state)
        IDLE: begin
          if (!redirect_valid && has_space) begin
            state    <= REQ;
            req_addr <= pc;
            arvalid  <= 1'b1;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            kill <= 1'b1;
          end
          if (arready) begin
            state   <= WAIT;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        WAIT: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (kill) begin
              kill  <= 1'b0;
              state <= IDLE;
            end else if (redirect_valid) begin
              state <= IDLE;
            end else if (!resp_fault) begin
              pc <= pc_seq;
              if (has_space_next) begin
                state    <= REQ;
                req_addr <= pc_seq;
                arvalid  <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              state <= HALT;
            end
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end
        HALT: begin
          if (redirect_valid) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          arvalid <= 1'b0;
          rready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
